pwm_receive: RTL and testbench

PWM_RECEIVE -- requirements
Module: pwm_receive

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pulse_timer.sv | 36 +++
 rtl/pwm_receive.sv | 125 ++++++++++++
 tb/tb_pwm_receive.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - pulse-width line timing constants and receiver states
// Shared with the transmit stage so both ends agree on nominal widths.
package pwm_pkg;

  localparam int SYNC_LO   = 400;
  localparam int SYNC_HI   = 600;
  localparam int SEND_LO   = 200;
  localparam int SEND_ZERO = 200;
  localparam int SEND_ONE  = 600;

  localparam int WIDTH_BITS = 10;
  localparam int WIDTH_MAX  = 1023;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC_HI,
    ST_BIT_LO,
    ST_BIT_HI
  } rx_state_t;

  // Inclusive tolerance window around a nominal width.
  function automatic logic in_window(input logic [WIDTH_BITS-1:0] width,
                                     input int nominal, input int tol);
    int w;
    w = 32'(width);
    return (w >= nominal - tol) && (w <= nominal + tol);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - line synchronizer, edge detector and level width counter
// width holds the length of the level that just ended while pulse_edge is high.
module pulse_timer
  import pwm_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sig_in,
  output logic                  pulse_edge,
  output logic                  level,
  output logic [WIDTH_BITS-1:0] width
);

  logic sync_1, sync_2, sync_3;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
      width  <= '0;
    end else begin
      sync_1 <= sig_in;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      if (pulse_edge)
        width <= WIDTH_BITS'(1);
      else if (width != WIDTH_BITS'(WIDTH_MAX))
        width <= width + 1'b1;
    end
  end

  assign pulse_edge = sync_2 ^ sync_3;
  assign level      = sync_2;

endmodule

// File: rtl/pwm_receive.sv
// rtl/pwm_receive.sv - pulse-width frame receiver
// Decodes a sync pulse followed by BIT_DEPTH width-coded bits, MSB first.
module pwm_receive
  import pwm_pkg::*;
#(
  parameter int BIT_DEPTH = 16,
  parameter int TOL       = 50
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 sig_in,
  output logic [BIT_DEPTH-1:0] data_out,
  output logic                 data_valid_out,
  output logic                 busy_out,
  output logic                 error_out
);

  localparam int CNT_BITS = $clog2(BIT_DEPTH + 1);
  localparam int HI_MAX   = SEND_ONE + TOL;
  localparam int LO_MAX   = SYNC_LO + TOL;

  logic                  pulse_edge, level;
  logic [WIDTH_BITS-1:0] width;

  rx_state_t             state, state_d;
  logic [BIT_DEPTH-1:0]  shift_q, shift_d, data_d;
  logic [CNT_BITS-1:0]   bit_cnt, bit_cnt_d;
  logic                  busy_d, valid_d, error_d;
  int                    limit;

  pulse_timer u_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .sig_in     (sig_in),
    .pulse_edge (pulse_edge),
    .level      (level),
    .width      (width)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= ST_HUNT;
      shift_q        <= '0;
      bit_cnt        <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      state          <= state_d;
      shift_q        <= shift_d;
      bit_cnt        <= bit_cnt_d;
      data_out       <= data_d;
      data_valid_out <= valid_d;
      busy_out       <= busy_d;
      error_out      <= error_d;
    end
  end

  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt;
    data_d    = data_out;
    busy_d    = busy_out;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    // The longest legal low is a resync pulse; the longest legal high is a one.
    limit     = (state == ST_BIT_LO) ? LO_MAX : HI_MAX;

    if (state != ST_HUNT && !pulse_edge && 32'(width) > limit) begin
      error_d = 1'b1;
      state_d = ST_HUNT;
    end else if (pulse_edge) begin
      case (state)
        ST_HUNT: begin
          if (level && in_window(width, SYNC_LO, TOL))
            state_d = ST_SYNC_HI;
        end
        ST_SYNC_HI: begin
          if (in_window(width, SYNC_HI, TOL)) begin
            state_d   = ST_BIT_LO;
            bit_cnt_d = '0;
            shift_d   = '0;
            busy_d    = 1'b1;
          end else begin
            error_d = 1'b1;
            state_d = ST_HUNT;
          end
        end
        ST_BIT_LO: begin
          if (in_window(width, SEND_LO, TOL)) begin
            state_d = ST_BIT_HI;
          end else begin
            error_d = 1'b1;
            state_d = in_window(width, SYNC_LO, TOL) ? ST_SYNC_HI : ST_HUNT;
          end
        end
        ST_BIT_HI: begin
          if (in_window(width, SEND_ZERO, TOL) || in_window(width, SEND_ONE, TOL)) begin
            shift_d = {shift_q[BIT_DEPTH-2:0], in_window(width, SEND_ONE, TOL)};
            if (bit_cnt == CNT_BITS'(BIT_DEPTH - 1)) begin
              data_d    = shift_d;
              valid_d   = 1'b1;
              busy_d    = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_HUNT;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
              state_d   = ST_BIT_LO;
            end
          end else begin
            error_d = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (error_d)
      busy_d = 1'b0;
  end

endmodule

// File: tb/tb_pwm_receive.sv
// tb/tb_pwm_receive.sv - scoreboard bench for pwm_receive
module tb_pwm_receive;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        sig_in = 1'b1;
  logic [15:0] data_out;
  logic        data_valid_out, busy_out, error_out;

  pwm_receive #(.BIT_DEPTH(16), .TOL(50)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .sig_in         (sig_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .busy_out       (busy_out),
    .error_out      (error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_rise = 0;
  int last_err = 0;
  int err_seen = 0;
  int n_strobes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_data = 16'h0;

  typedef struct {
    logic [15:0] d;
    int          nbits, slo, shi, lo, z, o;
    bit          ok;
    int          errs;
    string       name;
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every call starts and ends 1 time unit after a rising clock edge.
  task automatic level(input logic v, input int n);
    sig_in = v;
    if (v) last_rise = cyc;
    else   last_fall = cyc;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic frame(input logic [15:0] d, input int nbits, input int slo, input int shi,
                       input int lo, input int z, input int o, input bit expect_ok);
    level(1'b0, slo);
    level(1'b1, shi);
    for (int i = 15; i > 15 - nbits; i--) begin
      level(1'b0, lo);
      level(1'b1, d[i] ? o : z);
    end
    if (expect_ok) exp_q.push_back(d);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) exp_data = 16'h0;
    if (data_valid_out) begin
      n_strobes++;
      check("strobe_expected", 32'(exp_q.size() != 0), 1);
      check("valid_error_overlap", 32'(error_out), 0);
      check("valid_latency", cyc - last_fall, 3);
      if (exp_q.size() != 0) begin
        exp_data = exp_q.pop_front();
        check("frame_data", 32'(data_out), 32'(exp_data));
      end
    end
    if (error_out) begin
      err_seen++;
      last_err = cyc;
    end
  end

  initial begin
    int e0, s0;
    vecs[0] = '{16'hA5C3, 16, 400, 600, 200, 200, 600, 1'b1, 0, "nominal_a5c3"};
    vecs[1] = '{16'h8001, 16, 450, 650, 250, 250, 650, 1'b1, 0, "plus_tol"};
    vecs[2] = '{16'h8001, 16, 350, 550, 150, 150, 550, 1'b1, 0, "minus_tol"};
    vecs[3] = '{16'hA5C3,  2, 400, 600, 200, 251, 600, 1'b0, 1, "zero_hi_251"};
    vecs[4] = '{16'hA5C3,  1, 400, 600, 251, 200, 600, 1'b0, 1, "bit_lo_251"};
    vecs[5] = '{16'h8001,  1, 400, 600, 200, 200, 549, 1'b0, 1, "one_hi_549"};
    vecs[6] = '{16'h8001,  0, 400, 651, 200, 200, 600, 1'b0, 1, "sync_hi_651"};

    rst_in = 1'b0;
    sig_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_data", 32'(data_out), 0);
    check("reset_valid", 32'(data_valid_out), 0);
    check("reset_busy", 32'(busy_out), 0);
    check("reset_error", 32'(error_out), 0);
    rst_in = 1'b1;
    level(1'b1, 20);

    for (int k = 0; k < 7; k++) begin
      e0 = err_seen;
      frame(vecs[k].d, vecs[k].nbits, vecs[k].slo, vecs[k].shi,
            vecs[k].lo, vecs[k].z, vecs[k].o, vecs[k].ok);
      level(1'b0, 200);
      level(1'b1, 100);
      check({vecs[k].name, "_errors"}, err_seen - e0, vecs[k].errs);
      check({vecs[k].name, "_pending"}, exp_q.size(), 0);
      check({vecs[k].name, "_data"}, 32'(data_out), 32'(exp_data));
      check({vecs[k].name, "_busy"}, 32'(busy_out), 0);
    end

    // Sync pulse arriving after 7 bits forces a resync into the next frame.
    e0 = err_seen;
    frame(16'h0000, 7, 400, 600, 200, 200, 600, 1'b0);
    frame(16'h0001, 16, 400, 600, 200, 200, 600, 1'b1);
    level(1'b0, 200);
    level(1'b1, 100);
    check("resync_errors", err_seen - e0, 1);
    check("resync_pending", exp_q.size(), 0);
    check("resync_data", 32'(data_out), 32'h0001);

    // High held far past the longest legal bit.
    e0 = err_seen;
    frame(16'h0000, 3, 400, 600, 200, 200, 600, 1'b0);
    level(1'b0, 200);
    check("timeout_busy_before", 32'(busy_out), 1);
    level(1'b1, 2000);
    check("timeout_errors", err_seen - e0, 1);
    check("timeout_at_651", last_err - last_rise, 651 + 3);
    check("timeout_busy_after", 32'(busy_out), 0);
    check("timeout_data_hold", 32'(data_out), 32'h0001);

    // Reset in the middle of a frame.
    frame(16'h0000, 10, 400, 600, 200, 200, 600, 1'b0);
    check("midframe_busy", 32'(busy_out), 1);
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("midreset_data", 32'(data_out), 0);
    check("midreset_valid", 32'(data_valid_out), 0);
    check("midreset_busy", 32'(busy_out), 0);
    check("midreset_error", 32'(error_out), 0);
    rst_in = 1'b1;
    level(1'b1, 50);
    e0 = err_seen;
    s0 = n_strobes;
    frame(16'hFFFF, 16, 400, 600, 200, 200, 600, 1'b1);
    level(1'b0, 200);
    level(1'b1, 100);
    check("after_reset_errors", err_seen - e0, 0);
    check("after_reset_strobes", n_strobes - s0, 1);
    check("after_reset_data", 32'(data_out), 32'hFFFF);

    // Back-to-back frames: the next sync low starts at the last bit's fall.
    e0 = err_seen;
    s0 = n_strobes;
    frame(16'h1234, 16, 400, 600, 200, 200, 600, 1'b1);
    frame(16'hBEEF, 16, 400, 600, 200, 200, 600, 1'b1);
    level(1'b0, 200);
    level(1'b1, 100);
    check("b2b_errors", err_seen - e0, 0);
    check("b2b_strobes", n_strobes - s0, 2);
    check("b2b_pending", exp_q.size(), 0);
    check("b2b_data", 32'(data_out), 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
